// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state encoding and the width helper for the bit index.
package sar_search_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      SEARCH = ST_SEARCH,
      DONE   = ST_DONE
   } state_t;

   // A one-bit index is kept even for a one-bit datapath so the register never collapses.
   function automatic int idx_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/scomp.sv
// Unsigned magnitude comparator: reports whether a is above, below or equal to b.
module SCOMP #(
   parameter int DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic                 gt,
   output logic                 lt,
   output logic                 eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/sar_search.sv
// MSB-first binary search that recovers an unknown value seen only through
// the gt/lt/eq flags of a comparator whose b operand it drives.
module sar_search
   import sar_search_pkg::*;
#(
   parameter int DATAWIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic                 gt,
   input  logic                 lt,
   input  logic                 eq,
   output logic [DATAWIDTH-1:0] trial,
   output logic                 busy,
   output logic                 done,
   output logic [DATAWIDTH-1:0] result,
   output logic                 err
);

   localparam int IW = idx_width(DATAWIDTH);

   state_t               state, state_nxt;
   logic [IW-1:0]        idx, idx_nxt;
   logic [DATAWIDTH-1:0] acc, acc_nxt, acc_keep;
   logic [DATAWIDTH-1:0] trial_nxt, result_nxt;
   logic                 err_nxt;
   logic                 flags_ok;

   assign flags_ok = ({gt, lt, eq} == 3'b100) ||
                     ({gt, lt, eq} == 3'b010) ||
                     ({gt, lt, eq} == 3'b001);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state  <= IDLE;
         idx    <= '0;
         acc    <= '0;
         trial  <= '0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         acc    <= acc_nxt;
         trial  <= trial_nxt;
         result <= result_nxt;
         err    <= err_nxt;
      end
   end

   // One trial per SEARCH cycle; a gt keeps the bit under test, lt drops it.
   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      acc_nxt    = acc;
      trial_nxt  = trial;
      result_nxt = result;
      err_nxt    = err;
      acc_keep   = acc;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt              = SEARCH;
               trial_nxt              = '0;
               trial_nxt[DATAWIDTH-1] = 1'b1;
               idx_nxt                = IW'(DATAWIDTH - 1);
               acc_nxt                = '0;
               result_nxt             = '0;
               err_nxt                = 1'b0;
            end
         end
         SEARCH: begin
            if (!flags_ok) begin
               err_nxt    = 1'b1;
               result_nxt = acc;
               state_nxt  = DONE;
            end else if (eq) begin
               result_nxt = trial;
               state_nxt  = DONE;
            end else begin
               acc_keep = gt ? trial : acc;
               acc_nxt  = acc_keep;
               if (idx == '0) begin
                  result_nxt = acc_keep;
                  state_nxt  = DONE;
               end else begin
                  idx_nxt   = idx - IW'(1);
                  trial_nxt = acc_keep | (DATAWIDTH'(1) << (idx - IW'(1)));
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state == SEARCH);
   assign done = (state == DONE);

endmodule

// File: doc/sar_search.md
# sar_search

Sequential successive-approximation controller that sits on the driving side of an unsigned magnitude comparator. It owns the comparator's `b` operand and reads back the comparator's `gt`/`lt`/`eq` flags. From those flags it recovers the unknown value on the comparator's `a` operand with an MSB-first binary search. Used wherever a value is only observable through comparison, for example threshold discovery or ADC-style conversion.

## Interface
- `DATAWIDTH`, default 8: width of the trial value and the result.
- `Clk`  input  1  rising-edge clock.
- `Rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a new search; sampled only in IDLE.
- `gt`  input  1  comparator flag: unknown `a` > `trial`.
- `lt`  input  1  comparator flag: unknown `a` < `trial`.
- `eq`  input  1  comparator flag: unknown `a` == `trial`.
- `trial`  output  DATAWIDTH  registered value driven onto the comparator `b` operand.
- `busy`  output  1  high in SEARCH.
- `done`  output  1  one-cycle pulse; `result` is valid from this cycle on.
- `result`  output  DATAWIDTH  recovered value; held until the next accepted `start`.
- `err`  output  1  registered; set with `done` when the flags are not one-hot.

## Operation
- States: IDLE, SEARCH, DONE. Internal bit index `idx` is ceil(log2(DATAWIDTH)) bits wide.
- IDLE with `start`=1 → SEARCH:
  - `trial` = 1<<(DATAWIDTH-1)
  - `idx` = DATAWIDTH-1
  - `acc` = 0
  - `result` = 0
  - `err` = 0
- SEARCH evaluates the flags against the current `trial` on every cycle:
  - `eq`: `result` = `trial` → DONE.
  - `gt`: keep bit `idx`, so `acc` = `trial`.
  - `lt`: drop bit `idx`, so `acc` is unchanged.
  - If `idx`==0 after `gt`/`lt`: `result` = new `acc` → DONE.
  - Otherwise: `idx`-1, `trial` = new `acc` | (1<<(`idx`-1)).
- Flags not one-hot (none set, or more than one set): `err`=1, `result` = `acc` → DONE.
- DONE → IDLE unconditionally.
- `start` outside IDLE is ignored; it is not queued.
- All arithmetic is unsigned, DATAWIDTH bits. No carries occur because only single bits are OR-ed in.

## Timing
- Reset values: state IDLE, `trial`=0, `result`=0, `acc`=0, `idx`=0, `busy`=0, `done`=0, `err`=0.
- The comparator path is combinational. Flags are sampled on the same edge that follows each `trial` update, so each trial takes one SEARCH cycle.
- Latency from the `start` edge to `done` high: k+1 cycles.
  - k SEARCH cycles, with 1 ≤ k ≤ DATAWIDTH.
  - k < DATAWIDTH only on an early `eq`.
- `done` is high for exactly one cycle. `busy` is low in DONE.
- `start` held high continuously re-triggers on the cycle after DONE, i.e. back-to-back searches with one idle cycle between them.
- `Rst` asserted mid-search: all registers return to reset values immediately. After deassertion, no `done` is issued for the aborted search.
- `trial` holds its last value in IDLE/DONE; it returns to 0 only on reset.

## Structure
- Shared package holds:
  - the state encoding localparams (IDLE=2'd0, SEARCH=2'd1, DONE=2'd2);
  - the index-width function.
- Single module; no internal sub-module.
- The testbench instantiates the team's existing unsigned comparator (SCOMP) as the flag source, with `a` as the stimulus and `b` tied to `trial`.

## Test plan
All scenarios use DATAWIDTH=8.
- a=0x5A, pulse `start`:
  - trials in order 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A;
  - `done` after 7 SEARCH cycles with `result`=0x5A, `err`=0.
- a=0x00 → 8 SEARCH cycles, all flags `lt` → `result`=0x00. a=0xFF → `eq` at trial 0xFF on cycle 8 → `result`=0xFF.
- a=0x80 → `eq` on the first trial → `done` 2 cycles after `start` with `result`=0x80.
- Force gt=lt=eq=0 during the third SEARCH cycle → `err`=1 with `done`, `result`=0x40 (for a=0x5A).
- Assert `Rst` during the fourth SEARCH cycle → all outputs 0 and IDLE. A new `start` with a=0x21 → `result`=0x21.
- Pulse `start` while `busy` → ignored, and the current search finishes unchanged. Holding `start` high → the second search begins one cycle after DONE.
